// File: rtl/adder_pkg.sv
// adder_pkg: shared constants and types for the ripple-carry adder stage
// of the shift-and-add multiplier datapath.
package adder_pkg;

    // Default operand width of the adder stage.
    localparam int ADDER_WIDTH = 4;

    // Carry-preserving sum: one bit wider than the operands.
    typedef logic [ADDER_WIDTH:0] sum_t;

endpackage : adder_pkg

// File: rtl/adder_full_adder.sv
// full_adder: single-bit full-adder cell, the building block of the
// ripple-carry chain inside adder.
module full_adder (
    input  logic a,
    input  logic b,
    input  logic cin,
    output logic s,
    output logic cout
);

    // Sum is the three-way parity; carry is the majority of the inputs.
    always_comb begin
        s    = a ^ b ^ cin;
        cout = (a & b) | (a & cin) | (b & cin);
    end

endmodule : full_adder

// File: rtl/adder.sv
// adder: unsigned WIDTH-bit ripple-carry adder with a WIDTH+1-bit,
// carry-preserving result.
//
// Build option ADDER_OUTPUT_REG_EN:
//   defined   - Soma/Valido are registered on the rising Clock edge
//               (synchronous active-high Reset, 1-cycle latency).
//   undefined - Soma/Valido are combinational (0 latency); Clock and
//               Reset are kept as ports but unused.
//
// Output semantics: Valido qualifies Soma. There is no ready/backpressure;
// a result is presented exactly while Valido is high, and the consumer must
// take it then (in the registered build Soma also holds its last value
// while Enable stays low).
module adder
    import adder_pkg::*;
#(
    parameter int WIDTH = ADDER_WIDTH
) (
    input  logic             Clock,
    input  logic             Reset,
    input  logic             Enable,
    input  logic [WIDTH-1:0] OperandoA,
    input  logic [WIDTH-1:0] OperandoB,
    output logic [WIDTH:0]   Soma,
    output logic             Valido
);

    // carry[i] is the carry into cell i; carry[WIDTH] is the final carry-out.
    logic [WIDTH:0]   carry;
    logic [WIDTH-1:0] sum_bits;
    logic [WIDTH:0]   sum_next;

    assign carry[0] = 1'b0;

    // Explicit ripple chain, one full-adder cell per operand bit, so the
    // arithmetic does not depend on the synthesis tool's '+' inference.
    for (genvar i = 0; i < WIDTH; i++) begin : g_chain
        full_adder u_fa (
            .a    (OperandoA[i]),
            .b    (OperandoB[i]),
            .cin  (carry[i]),
            .s    (sum_bits[i]),
            .cout (carry[i+1])
        );
    end

    assign sum_next = {carry[WIDTH], sum_bits};

`ifdef ADDER_OUTPUT_REG_EN

    // Output register: Reset wins over Enable; Soma holds when idle, so
    // operand changes (including X) while Enable is low never reach Soma.
    always_ff @(posedge Clock) begin
        if (Reset) begin
            Soma   <= '0;
            Valido <= 1'b0;
        end else if (Enable) begin
            Soma   <= sum_next;
            Valido <= 1'b1;
        end else begin
            Valido <= 1'b0;
        end
    end

`else

    // Combinational build: the chain drives the outputs directly.
    assign Soma   = sum_next;
    assign Valido = Enable;

    logic unused_clk_rst;
    assign unused_clk_rst = Clock ^ Reset;

`endif

endmodule : adder

// File: tb/tb_adder.sv
// tb_adder: self-checking bench for adder. Expected sums come from plain
// integer addition of the zero-extended operands; a monitor pops the
// expected queue whenever Valido is high. Works in both
// ADDER_OUTPUT_REG_EN builds.
module tb_adder;
    import adder_pkg::*;

    localparam int W = ADDER_WIDTH;

    logic           clk;
    logic           rst;
    logic           en;
    logic [W-1:0]   a;
    logic [W-1:0]   b;
    logic [W:0]     soma;
    logic           valido;

    logic [W:0]     exp_q[$];
    int             n_tests;
    int             n_fail;

    adder #(.WIDTH(W)) dut (
        .Clock     (clk),
        .Reset     (rst),
        .Enable    (en),
        .OperandoA (a),
        .OperandoB (b),
        .Soma      (soma),
        .Valido    (valido)
    );

    // Clock and initial input values.
    initial begin
        clk = 1'b0;
        forever #5 clk = ~clk;
    end

    initial begin
        rst = 1'b1;
        en  = 1'b0;
        a   = '0;
        b   = '0;
        n_tests = 0;
        n_fail  = 0;
    end

    // Reference model: exact unsigned sum, never wraps.
    function automatic logic [W:0] ref_sum(input logic [W-1:0] x, input logic [W-1:0] y);
        int unsigned s;
        s = int'(x) + int'(y);
        return s[W:0];
    endfunction

    task automatic check(input string name, input logic [W:0] act_s, input logic [W:0] exp_s,
                         input logic act_v, input logic exp_v);
        n_tests++;
        if (act_s !== exp_s || act_v !== exp_v) begin
            n_fail++;
            $display("FAIL %s: Soma=%0d Valido=%0b, expected Soma=%0d Valido=%0b",
                     name, act_s, act_v, exp_s, exp_v);
        end
    endtask

    // Driver: apply one cycle of inputs just after the rising edge and
    // record the sum that should appear when Valido next rises.
    task automatic step(input logic r, input logic e, input logic [W-1:0] x, input logic [W-1:0] y);
        @(posedge clk);
        #1;
        rst = r;
        en  = e;
        a   = x;
        b   = y;
`ifdef ADDER_OUTPUT_REG_EN
        if (e && !r) exp_q.push_back(ref_sum(x, y));
`else
        if (e) exp_q.push_back(ref_sum(x, y));
`endif
    endtask

    // Directed observation at the falling edge of the current cycle.
    task automatic check_now(input string name, input logic [W:0] exp_s, input logic exp_v);
        @(negedge clk);
        check(name, soma, exp_s, valido, exp_v);
    endtask

    // Monitor / scoreboard: every valid result must match the oldest
    // outstanding expectation.
    initial begin
        forever begin
            @(negedge clk);
            if (valido === 1'b1) begin
                n_tests++;
                if (exp_q.size() == 0) begin
                    n_fail++;
                    $display("FAIL sb_unexpected: Valido=1 Soma=%0d, expected no result", soma);
                end else begin
                    logic [W:0] e;
                    e = exp_q.pop_front();
                    if (soma !== e) begin
                        n_fail++;
                        $display("FAIL sb_sum: Soma=%0d, expected %0d", soma, e);
                    end
                end
            end
        end
    end

    // Stimulus sequence.
    initial begin
`ifdef ADDER_OUTPUT_REG_EN
        // Reset held two cycles with Enable and maximal operands.
        step(1'b1, 1'b1, 4'd15, 4'd15);
        step(1'b1, 1'b1, 4'd15, 4'd15);
        check_now("reset_1", 5'd0, 1'b0);
        step(1'b0, 1'b1, 4'd8, 4'd7);
        check_now("reset_2", 5'd0, 1'b0);
        // Back-to-back captures, carry-out cases and boundaries.
        step(1'b0, 1'b1, 4'd9, 4'd7);
        check_now("sum_8_7", 5'd15, 1'b1);
        step(1'b0, 1'b1, 4'd10, 4'd10);
        check_now("sum_9_7", 5'd16, 1'b1);
        step(1'b0, 1'b1, 4'd9, 4'd5);
        check_now("sum_10_10", 5'd20, 1'b1);
        step(1'b0, 1'b1, 4'd15, 4'd15);
        check_now("sum_9_5", 5'd14, 1'b1);
        step(1'b0, 1'b1, 4'd0, 4'd0);
        check_now("max_15_15", 5'd30, 1'b1);
        step(1'b0, 1'b1, 4'd15, 4'd1);
        check_now("zero_0_0", 5'd0, 1'b1);
        step(1'b0, 1'b1, 4'd9, 4'd7);
        check_now("carry_15_1", 5'd16, 1'b1);
        // Enable drops while operands change: Soma holds, Valido falls.
        step(1'b0, 1'b0, 4'd3, 4'd3);
        check_now("hold_first", 5'd16, 1'b1);
        step(1'b0, 1'b0, 4'd3, 4'd3);
        check_now("hold_idle", 5'd16, 1'b0);
        // Reset on a capture edge discards the capture.
        step(1'b1, 1'b1, 4'd10, 4'd10);
        check_now("hold_before_rst", 5'd16, 1'b0);
        step(1'b0, 1'b1, 4'd9, 4'd5);
        check_now("rst_over_en", 5'd0, 1'b0);
        step(1'b0, 1'b0, 4'd0, 4'd0);
        check_now("after_rst_9_5", 5'd14, 1'b1);
        step(1'b0, 1'b0, 4'd0, 4'd0);
        check_now("idle_hold_14", 5'd14, 1'b0);
`else
        // Combinational build: outputs follow the inputs in the same cycle.
        step(1'b0, 1'b0, 4'd15, 4'd15);
        check_now("comb_max", 5'd30, 1'b0);
        step(1'b0, 1'b1, 4'd15, 4'd1);
        check_now("comb_carry", 5'd16, 1'b1);
        step(1'b1, 1'b0, 4'd0, 4'd0);
        check_now("comb_zero", 5'd0, 1'b0);
        step(1'b0, 1'b1, 4'd10, 4'd10);
        check_now("comb_10_10", 5'd20, 1'b1);
`endif
        // Exhaustive sweep of all operand pairs, back to back.
        for (int i = 0; i < (1 << W); i++) begin
            for (int j = 0; j < (1 << W); j++) begin
                step(1'b0, 1'b1, W'(i), W'(j));
            end
        end
        // Randomized traffic with idle gaps and occasional reset.
        for (int k = 0; k < 300; k++) begin
            step(($urandom_range(0, 19) == 0), ($urandom_range(0, 3) != 0),
                 W'($urandom), W'($urandom));
        end
        step(1'b0, 1'b0, '0, '0);
        step(1'b0, 1'b0, '0, '0);
        @(negedge clk);
        @(negedge clk);
        n_tests++;
        if (exp_q.size() != 0) begin
            n_fail++;
            $display("FAIL sb_drain: %0d results outstanding, expected 0", exp_q.size());
        end
        $display("[TB] %0d tests run, %0d failed", n_tests, n_fail);
        $finish;
    end

endmodule : tb_adder

// File: doc/adder.md
# adder

Unsigned WIDTH-bit adder with a registered, carry-preserving WIDTH+1-bit result. It is the addition stage of the shift-and-add multiplier datapath in the RISC project: partial products and operands enter on OperandoA/OperandoB and the full sum, including carry-out, is captured on the clock edge. The sum is built as an explicit ripple-carry chain so that it can be reused without relying on the synthesis tool's `+` inference.

## Interface
- WIDTH, default 4: operand width in bits; must be ≥ 1.
- Clock  input  1  rising-edge clock; the only clock.
- Reset  input  1  synchronous, active-high reset, sampled on the rising Clock edge.
- Enable  input  1  when high, the operands are summed and captured on this edge.
- OperandoA  input  WIDTH  unsigned addend A.
- OperandoB  input  WIDTH  unsigned addend B.
- Soma  output  WIDTH+1  unsigned sum A+B; the MSB is the carry-out.
- Valido  output  1  high for exactly the cycle after an Enable capture.

## Operation
- Sum rule: Soma = zero-extend(OperandoA) + zero-extend(OperandoB).
  - The result is exact and never wraps; no saturation or truncation is applied.
  - Maximum value is 2·(2^WIDTH−1), which is 30 for WIDTH=4.
- Combinational core: WIDTH full-adder cells in a ripple chain.
  - Cell 0 has carry-in fixed at 0.
  - Soma[WIDTH] = carry-out of cell WIDTH−1.
- Register update on each rising Clock edge, in this priority:
  - Reset=1: Soma ← 0 and Valido ← 0. Reset overrides Enable.
  - Else, Enable=1: Soma ← A+B of the sampled operands, and Valido ← 1.
  - Else: Soma holds its value and Valido ← 0.
- Operands are sampled only on the edge; changes between edges have no effect on the outputs.
- Back-to-back Enable: a new sum every cycle, with Valido held continuously high.
- X on the operands while Enable=0 must not propagate into Soma.

## Timing
- Reset values: Soma = 0, Valido = 0.
- Latency: 1 cycle from the Enable edge to Soma/Valido update. Throughput: 1 sum per cycle.
- Reset asserted during a capture edge: the capture is discarded; the outputs are 0 on the following cycle.
- Reset deasserted: the first capture is possible on the very next edge where Enable=1.
- No handshake backpressure; the consumer must read Soma while Valido is high or rely on the hold behaviour.
- The critical path is the WIDTH-cell ripple chain, which must settle within one Clock period.

## Configuration
- ADDER_OUTPUT_REG_EN defined: the registered behaviour described above.
- ADDER_OUTPUT_REG_EN undefined:
  - Soma = A+B combinationally.
  - Valido = Enable combinationally.
  - Clock and Reset remain as ports but are unused.
  - Latency is 0; there are no reset values.
- The arithmetic is identical in both builds.

## Structure
- Package adder_pkg holds:
  - the ADDER_WIDTH constant (4), used as the WIDTH default;
  - the sum type logic [ADDER_WIDTH:0].
- Sub-module full_adder has inputs a, b, cin and outputs s, cout.
  - s = a^b^cin; cout = majority(a, b, cin).
  - It is instantiated WIDTH times via generate.
- The top level contains only the chain, the output register, and the Valido flop.

## Test plan
- Reset held 2 cycles with Enable=1 and A=15, B=15 → Soma=0 and Valido=0 throughout.
- Enable=1, then A=8/B=7, A=9/B=7, A=10/B=10, A=9/B=5 on consecutive cycles → Soma = 15, 16, 20, 14 one cycle after each.
  - Valido stays high continuously.
  - 16 (5'b10000) and 20 (5'b10100) check the carry-out.
- Boundaries: A=15, B=15 → 30 (5'b11110); A=0, B=0 → 0; A=15, B=1 → 16.
- Enable deasserted after 9+7 while the operands change to 3/3 → Soma holds 16; Valido drops to 0 the next cycle.
- Reset asserted on the same edge as Enable with A=10, B=10 → Soma=0 and Valido=0; the next Enable with 9+5 → 14.
- Exhaustive sweep of all 256 operand pairs, compared with a reference model → zero mismatches, in both ADDER_OUTPUT_REG_EN builds.
